// File: rtl/key_conditioner.sv
// Pushbutton conditioner: synchronises each active-low key, debounces it with a
// per-key four-state qualifier and produces registered PRESS/RELEASE strobes and a HELD level.
module key_conditioner #(
    parameter int NKEYS           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NKEYS-1:0] KEY,
    output logic [NKEYS-1:0] PRESS,
    output logic [NKEYS-1:0] RELEASE,
    output logic [NKEYS-1:0] HELD
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        DOWN   = 2'd2,
        DISARM = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [NKEYS-1:0] s1_r;
    logic [NKEYS-1:0] s2_r;
    logic [NKEYS-1:0] raw_p_s;

    // Two-flop synchroniser; idles at 1 so a reset looks like "all released".
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_r <= {NKEYS{1'b1}};
            s2_r <= {NKEYS{1'b1}};
        end else begin
            s1_r <= KEY;
            s2_r <= s1_r;
        end
    end

    assign raw_p_s = ~s2_r;

    for (genvar k = 0; k < NKEYS; k++) begin : g_key
        state_t           state_r;
        state_t           state_nxt_s;
        logic [CNT_W-1:0] cnt_r;
        logic [CNT_W-1:0] cnt_nxt_s;
        logic             press_nxt_s;
        logic             release_nxt_s;
        logic             press_r;
        logic             release_r;
        logic             held_r;

        // Qualification FSM: a level must persist DEBOUNCE_CYCLES edges after ARM/DISARM entry.
        always_comb begin
            state_nxt_s   = state_r;
            cnt_nxt_s     = cnt_r;
            press_nxt_s   = 1'b0;
            release_nxt_s = 1'b0;
            case (state_r)
                IDLE: begin
                    if (raw_p_s[k]) begin
                        state_nxt_s = ARM;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                ARM: begin
                    if (!raw_p_s[k]) begin
                        state_nxt_s = IDLE;
                    end else if (cnt_r == CNT_LAST) begin
                        state_nxt_s = DOWN;
                        press_nxt_s = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                DOWN: begin
                    if (!raw_p_s[k]) begin
                        state_nxt_s = DISARM;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        state_nxt_s = DOWN;
                    end
                end
                DISARM: begin
                    if (raw_p_s[k]) begin
                        state_nxt_s = DOWN;
                    end else if (cnt_r == CNT_LAST) begin
                        state_nxt_s   = IDLE;
                        release_nxt_s = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end

        // State, counter and registered outputs; HELD follows the state being entered.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                state_r   <= IDLE;
                cnt_r     <= CNT_ZERO;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                held_r    <= 1'b0;
            end else begin
                state_r   <= state_nxt_s;
                cnt_r     <= cnt_nxt_s;
                press_r   <= press_nxt_s;
                release_r <= release_nxt_s;
                held_r    <= (state_nxt_s == DOWN) || (state_nxt_s == DISARM);
            end
        end

        assign PRESS[k]   = press_r;
        assign RELEASE[k] = release_r;
        assign HELD[k]    = held_r;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: a run-length reference model feeds a scoreboard
// that is compared against PRESS/RELEASE/HELD every cycle, plus directed latency checks.
module tb_key_conditioner;

    localparam int NKEYS = 4;
    localparam int D     = 4;
    localparam int CW    = 3;

    logic             CLK;
    logic             RST;
    logic [NKEYS-1:0] KEY;
    logic [NKEYS-1:0] PRESS;
    logic [NKEYS-1:0] RELEASE;
    logic [NKEYS-1:0] HELD;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [3*NKEYS-1:0] sb_q[$];

    // reference model state: two-stage delay, accepted level, opposite-level run length
    logic [NKEYS-1:0] m_p1;
    logic [NKEYS-1:0] m_p2;
    logic [NKEYS-1:0] m_h;
    int               m_run[NKEYS];

    key_conditioner #(
        .NKEYS          (NKEYS),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (CW)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .KEY    (KEY),
        .PRESS  (PRESS),
        .RELEASE(RELEASE),
        .HELD   (HELD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge();
        logic [NKEYS-1:0] pr;
        logic [NKEYS-1:0] rl;
        logic [NKEYS-1:0] raw;
        pr = '0;
        rl = '0;
        if (RST) begin
            m_p1 = '1;
            m_p2 = '1;
            m_h  = '0;
            for (int k = 0; k < NKEYS; k++) m_run[k] = 0;
        end else begin
            raw = ~m_p2;
            for (int k = 0; k < NKEYS; k++) begin
                if (raw[k] == m_h[k]) begin
                    m_run[k] = 0;
                end else begin
                    m_run[k]++;
                    if (m_run[k] == D + 1) begin
                        if (m_h[k]) rl[k] = 1'b1;
                        else        pr[k] = 1'b1;
                        m_h[k]   = ~m_h[k];
                        m_run[k] = 0;
                    end
                end
            end
            m_p2 = m_p1;
            m_p1 = KEY;
        end
        sb_q.push_back({pr, rl, m_h});
    endtask

    task automatic step();
        logic [3*NKEYS-1:0] exp;
        @(posedge CLK);
        cyc++;
        model_edge();
        #1;
        exp = sb_q.pop_front();
        chk("outs", {20'd0, PRESS, RELEASE, HELD}, {20'd0, exp});
    endtask

    task automatic hold(input int n);
        repeat (n) step();
    endtask

    task automatic wait_strobe(input int k, input bit rel, input int e0, input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if ((rel ? RELEASE[k] : PRESS[k]) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk(tag, got ? 32'(cyc - e0) : 32'hFFFF_FFFF, 32'(D + 2));
    endtask

    int  e0;
    int  npress;
    bit  seen_1010;

    initial begin
        RST = 1'b1;
        KEY = 4'hF;
        hold(3);
        chk("reset_outs", {20'd0, PRESS, RELEASE, HELD}, 32'd0);
        RST = 1'b0;
        hold(4);

        // basic press latency and held level
        e0 = cyc + 1;
        KEY[0] = 1'b0;
        wait_strobe(0, 1'b0, e0, "press0_lat");
        chk("press0_held", {31'd0, HELD[0]}, 32'd1);
        chk("press0_others", {28'd0, HELD[3:1], PRESS[3]}, 32'd0);
        hold(4);

        // release glitch of 2 cycles, then a real release
        KEY[0] = 1'b1;
        hold(2);
        KEY[0] = 1'b0;
        hold(8);
        chk("relglitch_held", {31'd0, HELD[0]}, 32'd1);
        e0 = cyc + 1;
        KEY[0] = 1'b1;
        wait_strobe(0, 1'b1, e0, "release0_lat");
        chk("release0_held", {31'd0, HELD[0]}, 32'd0);
        hold(4);

        // press bounce shorter than the window
        KEY[0] = 1'b0;
        hold(3);
        KEY[0] = 1'b1;
        hold(10);
        chk("bounce_held", {31'd0, HELD[0]}, 32'd0);

        // long hold: exactly one strobe, no auto-repeat
        KEY[0] = 1'b0;
        npress = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            npress += int'(PRESS[0]);
        end
        chk("long_press_cnt", 32'(npress), 32'd1);
        chk("long_held", {31'd0, HELD[0]}, 32'd1);
        KEY[0] = 1'b1;
        hold(12);

        // simultaneous presses on keys 1 and 3
        seen_1010 = 1'b0;
        KEY[1] = 1'b0;
        KEY[3] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (PRESS === 4'b1010) seen_1010 = 1'b1;
        end
        chk("press_1010", {31'd0, seen_1010}, 32'd1);
        chk("held_1010", {28'd0, HELD}, 32'hA);
        KEY = 4'hF;
        hold(12);

        // reset while key 2 is in ARM with cnt=2, key kept low
        KEY[2] = 1'b0;
        hold(5);
        #2;
        RST = 1'b1;
        #1;
        chk("rst_async_outs", {20'd0, PRESS, RELEASE, HELD}, 32'd0);
        hold(2);
        chk("rst_hold_outs", {20'd0, PRESS, RELEASE, HELD}, 32'd0);
        RST = 1'b0;
        e0 = cyc + 1;
        wait_strobe(2, 1'b0, e0, "press2_after_rst");
        chk("held2_after_rst", {28'd0, HELD}, 32'h4);
        KEY = 4'hF;
        hold(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
